// File: rtl/onehot_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_sel_pkg
// Description : Shared definitions for the one-hot selector encoder:
//               default geometry, FSM state type and the selector value
//               reported for illegal words.
// Revision    : 1.0 - initial release
// ============================================================================
package onehot_sel_pkg;

    // Default geometry of the selector path.
    localparam int N_OUT  = 8;
    localparam int N_USED = 6;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 8;

    // Selector reported whenever the input word is illegal.
    localparam int ILLEGAL_SEL = 0;

    // Output register occupancy.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage : onehot_sel_pkg
`default_nettype wire

// File: rtl/onehot_sel_enc_core.sv
`default_nettype none
// ============================================================================
// Module      : onehot_sel_enc_core
// Description : Purely combinational one-hot to binary selector encoder.
//               Only bits [N_USED-1:0] are legal codes.
//               Build option ONEHOT_SEL_ENCODER_PRIORITY_EN:
//                 undefined - strict: exactly one legal bit must be set.
//                 defined   - priority: lowest set bit wins, multi-hot is
//                             legal as long as that bit is a legal code.
// Ports       : in_onehot [N_OUT-1:0] - word to encode
//               sel       [SEL_W-1:0] - encoded selector (ILLEGAL_SEL if err)
//               err                   - word is illegal
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_sel_enc_core
    import onehot_sel_pkg::*;
#(
    parameter int N_OUT  = onehot_sel_pkg::N_OUT,
    parameter int N_USED = onehot_sel_pkg::N_USED,
    parameter int SEL_W  = onehot_sel_pkg::SEL_W
) (
    input  logic [N_OUT-1:0] in_onehot,
    output logic [SEL_W-1:0] sel,
    output logic             err
);

    logic [SEL_W-1:0] w_idx;
    logic             w_any_used;
    logic             w_legal;

    // Index of the lowest set bit; scanning downwards lets the lowest win.
    always_comb begin
        w_idx = '0;
        for (int i = N_OUT - 1; i >= 0; i--) begin
            if (in_onehot[i]) begin
                w_idx = i[SEL_W-1:0];
            end
        end
    end

    // The lowest set bit is a legal code exactly when some legal bit is set.
    assign w_any_used = |in_onehot[N_USED-1:0];

`ifdef ONEHOT_SEL_ENCODER_PRIORITY_EN
    assign w_legal = w_any_used;
`else
    // x & (x-1) clears the lowest set bit; anything left means multi-hot.
    logic w_multi;
    assign w_multi = |(in_onehot & (in_onehot - N_OUT'(1)));
    assign w_legal = w_any_used && !w_multi;
`endif

    assign sel = w_legal ? w_idx : SEL_W'(ILLEGAL_SEL);
    assign err = !w_legal;

endmodule : onehot_sel_enc_core
`default_nettype wire

// File: rtl/onehot_sel_encoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_sel_encoder
// Description : Encodes a one-hot status word back to a binary selector
//               behind one valid/ready output register stage, and keeps a
//               saturating count of accepted illegal words.
//               Build option ONEHOT_SEL_ENCODER_PRIORITY_EN selects priority
//               (lowest bit) encoding instead of strict one-hot checking.
// Ports       : clk, rst                  - clock, sync active-high reset
//               in_onehot/in_valid/in_ready - input handshake
//               out_sel/out_err/out_valid/out_ready - output handshake
//               err_cnt                   - saturating illegal-word count
//               err_clr                   - synchronous clear of err_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_sel_encoder
    import onehot_sel_pkg::*;
#(
    parameter int N_OUT  = onehot_sel_pkg::N_OUT,
    parameter int N_USED = onehot_sel_pkg::N_USED,
    parameter int SEL_W  = onehot_sel_pkg::SEL_W,
    parameter int CNT_W  = onehot_sel_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_OUT-1:0] in_onehot,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);

    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic [SEL_W-1:0] w_sel;
    logic             w_err;
    logic             w_accept;
    logic             w_xfer;

    onehot_sel_enc_core #(
        .N_OUT  (N_OUT),
        .N_USED (N_USED),
        .SEL_W  (SEL_W)
    ) u_core (
        .in_onehot (in_onehot),
        .sel       (w_sel),
        .err       (w_err)
    );

    // Ready when empty, or when full and the held word leaves this cycle.
    assign in_ready = (r_state == EMPTY) || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = (r_state == FULL) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_sel   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                EMPTY: if (w_accept) r_state <= FULL;
                FULL:  if (w_xfer && !w_accept) r_state <= EMPTY;
                default: r_state <= EMPTY;
            endcase

            // Only a new accept reloads the register, so a stalled word holds.
            if (w_accept) begin
                r_sel <= w_sel;
                r_err <= w_err;
            end

            // Clear wins over a simultaneous illegal accept.
            if (err_clr) begin
                r_cnt <= '0;
            end else if (w_accept && w_err && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_sel   = r_sel;
    assign out_err   = r_err;
    assign err_cnt   = r_cnt;

endmodule : onehot_sel_encoder
`default_nettype wire

// File: tb/tb_onehot_sel_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_sel_encoder
// Description : Scoreboard bench for onehot_sel_encoder. The driver pushes
//               the reference encoding of every accepted word; a separate
//               monitor checks handshake, output words and err_cnt.
//               Honours ONEHOT_SEL_ENCODER_PRIORITY_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_sel_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_onehot = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] out_sel;
    logic       out_err;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] err_cnt;
    logic       err_clr = 1'b0;

    int n_tot  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    logic [3:0] q[$];        // {err, sel} of words accepted, oldest first
    int         exp_cnt = 0;

    onehot_sel_encoder u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_onehot (in_onehot),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sel   (out_sel),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference encoder: lowest set bit and population count of the word.
    function automatic logic [3:0] ref_enc(input logic [7:0] w);
        int  low  = -1;
        int  ones = 0;
        bit  legal;
        for (int i = 0; i < 8; i++) begin
            if (w[i]) begin
                ones++;
                if (low < 0) low = i;
            end
        end
`ifdef ONEHOT_SEL_ENCODER_PRIORITY_EN
        legal = (low >= 0) && (low < 6);
`else
        legal = (ones == 1) && (low < 6);
`endif
        return legal ? {1'b0, 3'(low)} : 4'b1000;
    endfunction

    // One clock cycle of stimulus, entered and left at posedge+1.
    task automatic cyc(input logic v, input logic [7:0] d, input logic ordy,
                       input logic clr, input logic r);
        logic [3:0] e;
        in_valid = v; in_onehot = d; out_ready = ordy; err_clr = clr; rst = r;
        @(negedge clk); #2;
        if (r) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            e = ref_enc(d);
            // Monitor has already popped a transferring word this cycle.
            if (v && (ordy || q.size() == 0)) begin
                q.push_back(e);
                if (!clr && e[3] && exp_cnt != 255) exp_cnt++;
            end
            if (clr) exp_cnt = 0;
        end
        @(posedge clk); #1;
    endtask

    // Monitor: handshake, output word and counter checked every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                chk("in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
                chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
                chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
                if (out_valid && q.size() != 0) begin
                    chk("out_sel", 32'(out_sel), 32'(q[0][2:0]));
                    chk("out_err", 32'(out_err), 32'(q[0][3]));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        int k;
        @(posedge clk); #1;
        cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        mon_en = 1'b1;

        // First word and back-to-back legal stream.
        cyc(1, 8'h04, 1, 0, 0);
        chk("first_sel", 32'(out_sel), 32'd2);
        chk("first_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 6; i++) cyc(1, 8'(1 << i), 1, 0, 0);
        chk("stream_last_sel", 32'(out_sel), 32'd5);

        // Illegal words.
        cyc(1, 8'h40, 1, 0, 0);
        cyc(1, 8'h80, 1, 0, 0);
        cyc(1, 8'h00, 1, 0, 0);
        cyc(1, 8'h03, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
`ifdef ONEHOT_SEL_ENCODER_PRIORITY_EN
        chk("illegal_cnt", 32'(err_cnt), 32'd3);
`else
        chk("illegal_cnt", 32'(err_cnt), 32'd4);
`endif

        // Backpressure then same-cycle transfer plus accept.
        cyc(1, 8'h08, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'h10, 0, 0, 0);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_sel", 32'(out_sel), 32'd3);
        end
        cyc(1, 8'h10, 1, 0, 0);
        chk("reload_sel", 32'(out_sel), 32'd4);
        chk("reload_valid", 32'(out_valid), 32'd1);

        // Saturation and clear priority.
        cyc(0, 8'h00, 1, 1, 0);
        for (int i = 0; i < 300; i++) cyc(1, 8'h80, 1, 0, 0);
        chk("sat_cnt", 32'(err_cnt), 32'd255);
        cyc(1, 8'h80, 1, 1, 0);
        chk("clr_cnt", 32'(err_cnt), 32'd0);

        // Reset while full and stalled.
        cyc(1, 8'h01, 0, 0, 0);
        cyc(1, 8'h40, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 1);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_sel", 32'(out_sel), 32'd0);
        chk("mrst_err", 32'(out_err), 32'd0);
        chk("mrst_cnt", 32'(err_cnt), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(1, 0) == 1) d = 8'(1 << $urandom_range(7, 0));
            else d = 8'($urandom);
            cyc(($urandom_range(3, 0) != 0), d, ($urandom_range(9, 0) < 7),
                ($urandom_range(19, 0) == 0), ($urandom_range(99, 0) == 0));
        end

        // Drain with a bounded budget.
        k = 0;
        while (q.size() != 0 && k < 20) begin
            cyc(0, 8'h00, 1, 0, 0);
            k++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule : tb_onehot_sel_encoder
`default_nettype wire
